// File: rtl/kamus_pkg.sv
// Shared types for the kamus data-memory path.
package kamus_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/kamus_dmem_align.sv
// Combinational byte-lane logic: store strobes and lane placement, request
// legality, and load extraction from a captured word.
module kamus_dmem_align
  import kamus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_lane,
  output logic        err,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_width,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic        misaligned;
  logic        out_of_range;
  logic [31:0] ld_shift;

  always_comb begin
    strb       = 4'b0000;
    misaligned = 1'b0;
    case (mem_width_e'(width))
      MEM_B: strb = 4'b0001 << addr[1:0];
      MEM_H: begin
        strb       = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      MEM_W: begin
        strb       = 4'b1111;
        misaligned = |addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign out_of_range = {2'b00, addr[31:2]} >= DEPTH_WORDS;
  assign err          = misaligned | out_of_range;
  assign wdata_lane   = wdata << {addr[1:0], 3'b000};

  // Loads are zero-extended; sign extension happens in the core.
  assign ld_shift = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (mem_width_e'(ld_width))
      MEM_B:   ld_data = {24'h000000, ld_shift[7:0]};
      MEM_H:   ld_data = {16'h0000, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/kamus_dmem_resp.sv
// Single-outstanding data-memory responder with a fixed, parameterised
// response latency and byte-strobed word array.
module kamus_dmem_resp
  import kamus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_width_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             accept;
  logic             wr_en;
  logic [3:0]       strb;
  logic [31:0]      wdata_lane;
  logic             req_err;
  logic [31:0]      ld_data;
  logic [31:0]      rd_word_q;
  logic             err_q;
  logic             we_q;
  logic [1:0]       off_q;
  logic [1:0]       width_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem [DEPTH_WORDS];

  assign req_ready_o = (state_q == DMEM_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign wr_en       = accept && req_we_i && !req_err;
  assign idx         = req_addr_i[IDX_W+1:2];

  kamus_dmem_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_align (
    .addr      (req_addr_i),
    .width     (req_width_i),
    .wdata     (req_wdata_i),
    .strb      (strb),
    .wdata_lane(wdata_lane),
    .err       (req_err),
    .ld_off    (off_q),
    .ld_width  (width_q),
    .ld_word   (rd_word_q),
    .ld_data   (ld_data)
  );

  // Array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
    if (accept && !req_we_i) rd_word_q <= mem[idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= 2'd0;
      width_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= req_err;
        we_q    <= req_we_i;
        off_q   <= req_addr_i[1:0];
        width_q <= req_width_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY <= 1) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = DMEM_RESP;
      end
      DMEM_RESP: begin
        if (rsp_ready_i) state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Response fields come from registers captured at acceptance, so they
  // cannot move while the initiator stalls.
  assign rsp_valid_o = (state_q == DMEM_RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_kamus_dmem_resp.sv
// Directed and randomised checks of kamus_dmem_resp at LATENCY 1 and 3.
module tb_kamus_dmem_resp;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_we    [2];
  logic [1:0]  req_width [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] model [2][1024];
  int          lat_of [2];
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  rw;
  logic [1:0]  roff;
  logic [31:0] ra, rd, rexp;
  logic        rwe;
  int          t, lat, nresp;
  bit          got;

  always #5 clk = ~clk;

  kamus_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_we_i(req_we[0]),
    .req_width_i(req_width[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  kamus_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_we_i(req_we[1]),
    .req_width_i(req_width[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == B) ? 1 : (w == H) ? 2 : 4;
  endfunction

  function automatic void model_store(input int i, input logic [1:0] w,
                                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word;
    word = model[i][a[11:2]];
    for (int k = 0; k < nbytes(w); k++) word[8*(int'(a[1:0])+k) +: 8] = d[8*k +: 8];
    model[i][a[11:2]] = word;
  endfunction

  function automatic logic [31:0] model_load(input int i, input logic [1:0] w,
                                             input logic [31:0] a);
    logic [31:0] word;
    logic [31:0] r;
    word = model[i][a[11:2]];
    r    = 32'h0;
    for (int k = 0; k < nbytes(w); k++) r[8*k +: 8] = word[8*(int'(a[1:0])+k) +: 8];
    return r;
  endfunction

  // One request with immediate response acceptance and explicit expectations.
  task automatic txn(input int i, input logic we, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    int l;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1; req_we[i] = we; req_width[i] = w;
    req_addr[i]  = a;    req_wdata[i] = d; rsp_ready[i] = 1'b1;
    if (we && !exp_err) model_store(i, w, a, d);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    l = 1;
    while (!rsp_valid[i] && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    chk({tag, "_lat"}, 32'(l), 32'(lat_of[i]));
    chk({tag, "_rdata"}, rsp_rdata[i], exp_rd);
    chk({tag, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(rsp_valid[i]), 32'd0);
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    lat_of[0] = 1;
    lat_of[1] = 3;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = 32'h0; req_we[i] = 1'b0;
      req_width[i] = 2'b00; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rdata", rsp_rdata[i], 32'h0);
      chk("rst_err", 32'(rsp_err[i]), 32'd0);
    end

    // LATENCY=1 directed
    txn(0, 1'b1, W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_w");
    txn(0, 1'b0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w");
    txn(0, 1'b1, B, 32'h13, 32'h000000AA, 32'h0, 1'b0, "st_b");
    txn(0, 1'b0, W, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, "ld_w_merge");
    txn(0, 1'b0, B, 32'h13, 32'h0, 32'h000000AA, 1'b0, "ld_b");
    txn(0, 1'b0, H, 32'h12, 32'h0, 32'h0000AAAD, 1'b0, "ld_h");
    txn(0, 1'b1, H, 32'h10, 32'h1234CAFE, 32'h0, 1'b0, "st_h");
    txn(0, 1'b0, W, 32'h10, 32'h0, 32'hAAADCAFE, 1'b0, "ld_w_h");
    txn(0, 1'b0, B, 32'h11, 32'h0, 32'h000000CA, 1'b0, "ld_b1");
    txn(0, 1'b0, H, 32'h11, 32'h0, 32'h0, 1'b1, "err_ld_h");
    txn(0, 1'b0, W, 32'h12, 32'h0, 32'h0, 1'b1, "err_ld_w");
    txn(0, 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, "err_width");
    txn(0, 1'b0, W, 32'h1000, 32'h0, 32'h0, 1'b1, "err_range");
    txn(0, 1'b1, W, 32'h0, 32'h01020304, 32'h0, 1'b0, "st_w0");
    txn(0, 1'b1, W, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, "err_st_range");
    txn(0, 1'b1, W, 32'h11, 32'h55555555, 32'h0, 1'b1, "err_st_align");
    txn(0, 1'b1, 2'b11, 32'h10, 32'h55555555, 32'h0, 1'b1, "err_st_width");
    txn(0, 1'b0, W, 32'h0, 32'h0, 32'h01020304, 1'b0, "ld_w0_kept");
    txn(0, 1'b0, W, 32'h10, 32'h0, 32'hAAADCAFE, 1'b0, "ld_w_kept");

    // LATENCY=3: stalled response, and a request held while busy is ignored
    txn(1, 1'b1, W, 32'h40, 32'h11223344, 32'h0, 1'b0, "l3_st");
    @(negedge clk);
    chk("l3_hold_rdy", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_width[1] = W; req_addr[1] = 32'h40;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_we[1] = 1'b1; req_wdata[1] = 32'hBADBAD00;
    for (int k = 1; k <= 7; k++) begin
      chk("l3_hold_valid", 32'(rsp_valid[1]), (k >= 3) ? 32'd1 : 32'd0);
      chk("l3_hold_rdata", rsp_rdata[1], (k >= 3) ? 32'h11223344 : 32'h0);
      chk("l3_hold_ready", 32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("l3_hs_valid", 32'(rsp_valid[1]), 32'd0);
    chk("l3_hs_ready", 32'(req_ready[1]), 32'd1);
    chk("l3_hs_rdata", rsp_rdata[1], 32'h0);
    rsp_ready[1] = 1'b0;
    txn(1, 1'b0, W, 32'h40, 32'h0, 32'h11223344, 1'b0, "l3_ignored");

    // Reset while waiting after an accepted store
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_width[1] = W;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("wait_valid", 32'(rsp_valid[1]), 32'd0);
    chk("wait_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready[1]), 32'd1);
    chk("arst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("arst_rdata", rsp_rdata[1], 32'h0);
    chk("arst_err", 32'(rsp_err[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_valid", 32'(rsp_valid[1]), 32'd0);
    end
    rsp_ready[1] = 1'b0;
    txn(1, 1'b0, W, 32'h20, 32'h0, 32'h12345678, 1'b0, "arst_kept");

    // Random legal traffic against the byte model, random response stalls
    for (int i = 0; i < 2; i++) begin
      for (int wd = 0; wd < 16; wd++)
        txn(i, 1'b1, W, 32'(wd * 4), $urandom, 32'h0, 1'b0, "rnd_init");
      nresp = 0;
      for (int n = 0; n < 100; n++) begin
        rw   = 2'($urandom_range(0, 2));
        rwe  = 1'($urandom_range(0, 1));
        roff = (rw == B) ? 2'($urandom_range(0, 3)) :
               (rw == H) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
        ra   = {26'h0, 4'($urandom_range(0, 15)), roff};
        rd   = $urandom;
        @(negedge clk);
        req_valid[i] = 1'b1; req_we[i] = rwe; req_width[i] = rw;
        req_addr[i] = ra; req_wdata[i] = rd;
        t = 0;
        while (!req_ready[i] && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("rnd_accept", 32'(req_ready[i]), 32'd1);
        rexp = rwe ? 32'h0 : model_load(i, rw, ra);
        if (rwe) model_store(i, rw, ra, rd);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        got = 1'b0;
        t = 0;
        while (!got && t < 50) begin
          @(negedge clk);
          rsp_ready[i] = 1'($urandom_range(0, 1));
          if (rsp_valid[i]) begin
            chk("rnd_rdata", rsp_rdata[i], rexp);
            chk("rnd_err", 32'(rsp_err[i]), 32'd0);
            if (rsp_ready[i]) got = 1'b1;
          end
          t++;
        end
        chk("rnd_resp", 32'(got), 32'd1);
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        chk("rnd_nodup", 32'(rsp_valid[i]), 32'd0);
        if (got) nresp++;
      end
      chk("rnd_count", 32'(nresp), 32'd100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
